// File: rtl/life_gen_engine_if.sv
// Control/status bundle between the Game-of-Life engine and its driver/renderer.
interface life_gen_engine_if #(
  parameter int WIDTH  = 3,
  parameter int HEIGHT = 3
);
  localparam int AW   = WIDTH + HEIGHT;
  localparam int SIZE = 2 ** AW;

  logic            frame_tick;
  logic            run;
  logic            load;
  logic [SIZE-1:0] seed;
  logic [AW-1:0]   rd_addr;
  logic            rd_cell;
  logic            busy;
  logic            gen_done;
  logic [15:0]     generation;

  modport master (
    output frame_tick, run, load, seed, rd_addr,
    input  rd_cell, busy, gen_done, generation
  );

  modport slave (
    input  frame_tick, run, load, seed, rd_addr,
    output rd_cell, busy, gen_done, generation
  );
endinterface

// File: rtl/life_gen_engine.sv
// Game-of-Life generation engine: sweeps one cell per clock into a scratch
// board and commits it atomically, paced by frame ticks.
module life_gen_engine #(
  parameter int WIDTH          = 3,
  parameter int HEIGHT         = 3,
  parameter int FRAMES_PER_GEN = 60,
  parameter logic [2**(WIDTH+HEIGHT)-1:0] RESET_PATTERN = 64'h0000_0000_0007_0402
) (
  input  logic              clk,
  input  logic              rst_n,
  life_gen_engine_if.slave  bus
);
  localparam int AW   = WIDTH + HEIGHT;
  localparam int SIZE = 2 ** AW;
  localparam int COLS = 2 ** WIDTH;
  localparam int ROWS = 2 ** HEIGHT;
  localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_GEN - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, COMMIT} state_t;

  state_t          state;
  logic [SIZE-1:0] cur;
  logic [SIZE-1:0] nxt;
  logic [AW-1:0]   idx;
  logic [7:0]      frame_cnt;
  logic [15:0]     gen_cnt;
  logic            busy_q;
  logic            gen_done_q;

  logic [HEIGHT-1:0] row;
  logic [WIDTH-1:0]  col;
  logic [3:0]        nbr;
  int                nr;
  int                nc;
  logic              cell_next;
  logic              start_req;

  assign row = idx[AW-1:WIDTH];
  assign col = idx[WIDTH-1:0];

  // Off-board neighbours count as dead; no wrap-around.
  always_comb begin
    nbr = '0;
    nr  = 0;
    nc  = 0;
    for (int unsigned dr = 0; dr < 3; dr++) begin
      for (int unsigned dc = 0; dc < 3; dc++) begin
        nr = int'(row) + int'(dr) - 1;
        nc = int'(col) + int'(dc) - 1;
        if (!(dr == 1 && dc == 1) && nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS)
          nbr = nbr + 4'(cur[AW'(nr * COLS + nc)]);
      end
    end
    cell_next = (nbr == 4'd3) || (cur[idx] && nbr == 4'd2);
  end

  assign start_req = bus.run && bus.frame_tick && (frame_cnt == LAST_FRAME);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur        <= RESET_PATTERN;
      nxt        <= '0;
      idx        <= '0;
      frame_cnt  <= '0;
      gen_cnt    <= '0;
      busy_q     <= 1'b0;
      gen_done_q <= 1'b0;
    end else if (bus.load) begin
      state      <= IDLE;
      cur        <= bus.seed;
      idx        <= '0;
      frame_cnt  <= '0;
      gen_cnt    <= '0;
      busy_q     <= 1'b0;
      gen_done_q <= 1'b0;
    end else begin
      gen_done_q <= 1'b0;
      if (bus.run && bus.frame_tick)
        frame_cnt <= (frame_cnt == LAST_FRAME) ? '0 : frame_cnt + 8'd1;
      case (state)
        IDLE: begin
          if (start_req) begin
            state  <= SWEEP;
            idx    <= '0;
            busy_q <= 1'b1;
          end
        end
        SWEEP: begin
          nxt[idx] <= cell_next;
          idx      <= idx + AW'(1);
          if (idx == AW'(SIZE - 1))
            state <= COMMIT;
        end
        COMMIT: begin
          cur        <= nxt;
          gen_cnt    <= gen_cnt + 16'd1;
          gen_done_q <= 1'b1;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_cell    = cur[bus.rd_addr];
  assign bus.busy       = busy_q;
  assign bus.gen_done   = gen_done_q;
  assign bus.generation = gen_cnt;
endmodule

// File: tb/tb_life_gen_engine.sv
// Bench for life_gen_engine: vector table plus random boards against a
// coordinate-based Life model, and hand sequences for pacing and load abort.
module tb_life_gen_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #100 clk = ~clk;

  life_gen_engine_if #(.WIDTH(3), .HEIGHT(3)) b1 ();
  life_gen_engine_if #(.WIDTH(3), .HEIGHT(3)) b60 ();

  life_gen_engine #(.FRAMES_PER_GEN(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(b1));
  life_gen_engine #(.FRAMES_PER_GEN(60)) dut60 (.clk(clk), .rst_n(rst_n), .bus(b60));

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [63:0] seed;
    int          gens;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[$];

  localparam logic [63:0] RST_PAT = 64'h0000_0000_0007_0402;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 8x8 grid, dead border, count neighbours by coordinates.
  function automatic logic [63:0] life_step(input logic [63:0] b);
    logic [63:0] s;
    int n;
    s = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
              n += int'(b[6'((r + dr) * 8 + c + dc)]);
        s[6'(r * 8 + c)] = (n == 3) || (b[6'(r * 8 + c)] && n == 2);
      end
    return s;
  endfunction

  task automatic read_board(input int which, output logic [63:0] b);
    for (int i = 0; i < 64; i++) begin
      if (which == 1) b1.rd_addr = 6'(i);
      else            b60.rd_addr = 6'(i);
      #1;
      b[i] = (which == 1) ? b1.rd_cell : b60.rd_cell;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load1(input logic [63:0] s);
    b1.seed = s;
    b1.load = 1'b1;
    cycle();
    b1.load = 1'b0;
  endtask

  // Pulse one tick on dut1 and count edges until gen_done is seen (bounded).
  task automatic tick_wait1(output int cyc);
    b1.frame_tick = 1'b1;
    cycle();
    b1.frame_tick = 1'b0;
    cyc = 1;
    while (!b1.gen_done && cyc < 200) begin
      cycle();
      cyc++;
    end
  endtask

  initial begin
    #(200 * 50000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] brd, brd0, e;
    logic [15:0] g0;
    int cyc;
    logic seen;

    b1.frame_tick = 0; b1.run = 0; b1.load = 0; b1.seed = '0; b1.rd_addr = '0;
    b60.frame_tick = 0; b60.run = 0; b60.load = 0; b60.seed = '0; b60.rd_addr = '0;

    vecs.push_back('{"blinker1",  64'h0000_0000_0000_0E00, 1, 64'h0000_0000_0004_0404});
    vecs.push_back('{"blinker2",  64'h0000_0000_0000_0E00, 2, 64'h0000_0000_0000_0E00});
    vecs.push_back('{"block3",    64'h0000_0000_0000_0303, 3, 64'h0000_0000_0000_0303});
    vecs.push_back('{"corner63",  64'h8000_0000_0000_0000, 1, 64'h0});
    vecs.push_back('{"glider4",   RST_PAT,                 4, 64'h0000_0000_0E08_0400});
    for (int k = 0; k < 8; k++) begin
      vec_t v;
      v.name = $sformatf("rand%0d", k);
      v.seed = {$urandom, $urandom};
      v.gens = $urandom_range(1, 3);
      e = v.seed;
      for (int g = 0; g < v.gens; g++) e = life_step(e);
      v.exp = e;
      vecs.push_back(v);
    end

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    read_board(1, brd);
    chk("reset board", brd, RST_PAT);
    chk("reset gen", 64'(b1.generation), 64'd0);
    chk("reset busy", 64'(b1.busy), 64'd0);
    chk("reset gen_done", 64'(b1.gen_done), 64'd0);
    chk("reset busy60", 64'(b60.busy), 64'd0);

    // Glider from reset, ticks spaced >= 70 cycles
    b1.run = 1'b1;
    for (int g = 0; g < 4; g++) begin
      tick_wait1(cyc);
      chk($sformatf("glider latency%0d", g), 64'(cyc), 64'd66);
      repeat (5) cycle();
    end
    read_board(1, brd);
    chk("glider board", brd, 64'h0000_0000_0E08_0400);
    chk("glider gen", 64'(b1.generation), 64'd4);

    // Table-driven vectors
    foreach (vecs[i]) begin
      load1(vecs[i].seed);
      chk({vecs[i].name, " load gen"}, 64'(b1.generation), 64'd0);
      for (int g = 0; g < vecs[i].gens; g++) begin
        tick_wait1(cyc);
        chk($sformatf("%s latency%0d", vecs[i].name, g), 64'(cyc), 64'd66);
        cycle();
      end
      read_board(1, brd);
      chk({vecs[i].name, " board"}, brd, vecs[i].exp);
      chk({vecs[i].name, " gen"}, 64'(b1.generation), 64'(vecs[i].gens));
    end

    // Load mid-sweep aborts without gen_done
    load1(64'h0000_0000_0000_0E00);
    b1.frame_tick = 1'b1;
    cycle();
    b1.frame_tick = 1'b0;
    chk("midsweep busy before", 64'(b1.busy), 64'd1);
    repeat (19) cycle();
    load1(64'h0);
    chk("midsweep busy", 64'(b1.busy), 64'd0);
    read_board(1, brd);
    chk("midsweep board", brd, 64'h0);
    chk("midsweep gen", 64'(b1.generation), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (b1.gen_done || b1.busy) seen = 1'b1;
      cycle();
    end
    chk("midsweep no gen_done", 64'(seen), 64'd0);

    // Load and tick together: tick ignored
    b1.seed = 64'h0000_0000_0000_0E00;
    b1.load = 1'b1;
    b1.frame_tick = 1'b1;
    cycle();
    b1.load = 1'b0;
    b1.frame_tick = 1'b0;
    cycle();
    chk("load+tick busy", 64'(b1.busy), 64'd0);
    read_board(1, brd);
    chk("load+tick board", brd, 64'h0000_0000_0000_0E00);

    // Pacing with FRAMES_PER_GEN=60
    b60.run = 1'b1;
    seen = 1'b0;
    for (int t = 1; t < 60; t++) begin
      b60.frame_tick = 1'b1;
      cycle();
      b60.frame_tick = 1'b0;
      if (b60.busy) seen = 1'b1;
      cycle();
      if (b60.busy) seen = 1'b1;
    end
    chk("pace ticks1-59 idle", 64'(seen), 64'd0);
    b60.frame_tick = 1'b1;
    cycle();
    b60.frame_tick = 1'b0;
    chk("pace tick60 busy", 64'(b60.busy), 64'd1);
    cyc = 1;
    while (!b60.gen_done && cyc < 200) begin
      cycle();
      cyc++;
    end
    chk("pace latency", 64'(cyc), 64'd66);
    chk("pace gen", 64'(b60.generation), 64'd1);
    read_board(2, brd);
    chk("pace board", brd, life_step(RST_PAT));

    b60.run = 1'b0;
    cycle();
    read_board(2, brd0);
    g0 = b60.generation;
    seen = 1'b0;
    for (int t = 0; t < 200; t++) begin
      b60.frame_tick = 1'b1;
      cycle();
      b60.frame_tick = 1'b0;
      if (b60.busy || b60.gen_done) seen = 1'b1;
      cycle();
    end
    chk("run0 no activity", 64'(seen), 64'd0);
    read_board(2, brd);
    chk("run0 board", brd, brd0);
    chk("run0 gen", 64'(b60.generation), 64'(g0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/life_gen_engine.md
# life_gen_engine

Sequential Game-of-Life generation engine feeding the VGA board renderer. It holds the displayed board and paces generations from the vertical-sync frame tick. Each generation is computed one cell per clock into a scratch buffer, then committed atomically. The renderer reads cells through a combinational read port, so it never sees a half-updated board.

## Interface
Parameters:
- WIDTH, 3, log2 of board width (columns = 2**WIDTH)
- HEIGHT, 3, log2 of board height (rows = 2**HEIGHT); SIZE = 2**(WIDTH+HEIGHT)
- FRAMES_PER_GEN, 60, frame ticks per generation while running; legal range 1..256
- RESET_PATTERN, 64'h0000_0000_0007_0402, board loaded at reset (glider: cells 1,10,16,17,18)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset, synchronous, active-low
- frame_tick  in  1  one-cycle pulse per frame, from the vsync edge
- run  in  1  1 = advance generations; 0 = hold the board
- load  in  1  one-cycle pulse: replace board with seed
- seed  in  SIZE  pattern to load; bit idx = row*2**WIDTH + col
- rd_addr  in  WIDTH+HEIGHT  renderer cell index
- rd_cell  out  1  displayed board bit at rd_addr, combinational
- busy  out  1  sweep/commit in progress
- gen_done  out  1  one-cycle pulse when a new generation becomes visible
- generation  out  16  generation count since reset/load

## Operation
- Storage: cur[SIZE-1:0] (displayed), nxt[SIZE-1:0] (scratch), idx counter (WIDTH+HEIGHT bits), frame counter (8 bits).
- Cell index mapping: row = idx[WIDTH+HEIGHT-1:WIDTH], col = idx[WIDTH-1:0].
- Neighbours: the 8 surrounding cells of cur. Positions outside the board are dead; there is no wrap-around.
- Rule: live with 2 or 3 neighbours survives; dead with exactly 3 is born; otherwise the cell is dead. Neighbour count is a 4-bit value (0..8).
- FSM states:
  - IDLE: waits for a start request.
  - SWEEP: each cycle, nxt[idx] <= rule(cur, idx) and idx increments. When idx == SIZE-1, go to COMMIT.
  - COMMIT: cur <= nxt; generation increments, wrapping at 16 bits; go to IDLE.
- Pacing, in any state while run=1: each frame_tick increments the frame counter.
  - On the tick where the counter equals FRAMES_PER_GEN-1, the counter clears to 0 and a start request is raised.
  - A request taken in IDLE moves to SWEEP with idx=0. A request arriving in SWEEP or COMMIT is dropped.
- run=0: the frame counter holds and no requests are raised. A sweep already in progress completes.
- load, highest priority, accepted in any state:
  - cur <= seed; generation <= 0; frame counter <= 0; idx <= 0; state <= IDLE.
  - An in-flight sweep is aborted and nxt contents are discarded.
  - gen_done is not pulsed.
- load and frame_tick in the same cycle: load wins and the tick is ignored.
- Reset (rst_n=0 at a clk edge): cur = RESET_PATTERN; nxt = 0; generation = 0; frame counter = 0; idx = 0; state IDLE; busy = 0; gen_done = 0.

## Timing
- Start: request at edge T enters SWEEP. busy is high from T+1 for SIZE+1 cycles (SIZE sweep cycles plus 1 commit cycle).
- cur changes only at the COMMIT edge, all bits simultaneously.
- gen_done is registered: high for the single cycle after the COMMIT edge, coincident with the new cur and the incremented generation.
- rd_cell = cur[rd_addr] with zero latency. The renderer must tolerate one board change per generation at an arbitrary pixel; this is acceptable because the commit is atomic.
- busy is registered; it is 0 in IDLE and 1 in SWEEP and COMMIT.
- With defaults, a generation takes 65 cycles, far less than one frame, so requests are never dropped in normal use.

## Test plan
- Reset: hold rst_n=0 for 2 cycles. Then cur == 64'h...0007_0402, generation = 0, busy = 0, gen_done = 0.
- Blinker: load seed with bits 9,10,11; run=1; FRAMES_PER_GEN=1; one frame_tick.
  - gen_done fires 66 cycles later and cur has exactly bits 2,10,18.
  - A second tick returns cur to bits 9,10,11.
- Still life and edges:
  - Seed bits 0,1,8,9 are unchanged after 3 generations.
  - Seed with bit 63 alone becomes all-zero after 1 generation, with no wrap births at bits 0, 7 or 56.
- Glider: from reset, run=1, FRAMES_PER_GEN=1, 4 ticks spaced at least 70 cycles apart.
  - cur has exactly bits 10,19,25,26,27 and generation = 4.
- Pacing, FRAMES_PER_GEN=60:
  - Ticks 1..59 start nothing; tick 60 starts a sweep.
  - With run=0, 200 ticks leave cur and generation unchanged.
- Load mid-sweep: pulse load with seed = 0 twenty cycles into a sweep.
  - Next cycle: busy = 0, cur = 0, generation = 0.
  - No gen_done pulse occurs.
